pcm_deframer: RTL and testbench
===============================

Name: pcm_deframer

Overview:
- Serial-to-parallel framing stage between the FSK demodulator's recovered bit stream and the log-to-linear PCM expander.
- Hunts for an 8-bit frame sync word, then slices each frame's payload into 8-bit log-PCM codes, each presented with a one-cycle valid strobe.
- A flywheel tolerates isolated sync errors and drops lock after MISS_LIMIT consecutive missed sync words.

Parameters:
SYNC_WORD, 8'h9B, frame alignment word, transmitted MSB first
N_SLOTS, 4, payload bytes per frame following the sync word (range 1..255)
MISS_LIMIT, 3, consecutive sync mismatches that cause loss of lock (range 1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  recovered serial data bit, sampled only when bit_valid=1
bit_valid  input  1  one-cycle strobe per received bit; any spacing >=1 cycle allowed, including back-to-back
pcmlog  output  8  log-PCM code of the last completed slot, held between strobes
pcm_valid  output  1  one-cycle pulse: pcmlog carries a new code
slot_idx  output  SLOT_W  slot number (0..N_SLOTS-1) of the current pcmlog; SLOT_W = max(1,clog2(N_SLOTS))
locked  output  1  high while state is PAYLOAD or SYNC_CHECK
sync_loss  output  1  one-cycle pulse when lock is dropped

Behaviour:
- Reset (async assert, sync release): state=HUNT, shift register=0, bit counter=0, slot counter=0, miss counter=0. Outputs: pcmlog=0, pcm_valid=0, slot_idx=0, locked=0, sync_loss=0.
- Bit order is MSB first. Shift register update on bit_valid: shreg <= {shreg[6:0], bit_in}. Define nxt = {shreg[6:0], bit_in}.
- All decisions occur on the bit_valid cycle. Outputs and state update at the next clock edge, so latency is 1 cycle. With bit_valid=0, nothing changes except that the pulse outputs return to 0.
- HUNT:
  - Compares nxt==SYNC_WORD on every bit_valid. This is a bit-by-bit sliding search, so overlapping candidates are found.
  - On a match: go to PAYLOAD, clear bit and slot counters, clear miss counter. locked rises 1 cycle after the matching bit.
  - No pcm_valid is ever issued in HUNT.
- PAYLOAD:
  - Counts 8 bits per slot. On the 8th bit: pcmlog<=nxt, slot_idx<=slot counter, pcm_valid=1 for one cycle.
  - After slot N_SLOTS-1 completes: go to SYNC_CHECK with the bit counter cleared.
- SYNC_CHECK:
  - Counts 8 bits. On the 8th bit, compares nxt with SYNC_WORD.
    - Match: miss counter cleared, go to PAYLOAD.
    - Mismatch with miss+1 < MISS_LIMIT: miss counter incremented, go to PAYLOAD. This is the flywheel; payload is still delivered.
    - Mismatch with miss+1 == MISS_LIMIT: go to HUNT, sync_loss=1 for one cycle, locked falls the same edge, miss counter cleared.
  - After a loss, hunting restarts from the next bit. The shift register is retained, so a sync word ending exactly at the loss bit is not re-detected.
- The sync comparison is exact, with no bit-error tolerance.
- Back-to-back bit_valid at full clock rate must be supported with no dropped bits.
- Reset mid-frame: immediate return to HUNT. Any partial slot is discarded and no pcm_valid is emitted.

Decomposition:
- Shared package pcm_pkg:
  - state enum {HUNT, PAYLOAD, SYNC_CHECK}
  - PCM_LOG_W=8
  - PCM_LIN_W=13
  - default SYNC_WORD
- One natural sub-module: pcm_bit_shifter (8-bit serial-in/parallel-out shift register with a bit_valid enable and a 3-bit bit counter that raises byte_done).
- The FSM and counters stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-stream, including during a bit_valid -> all outputs 0 immediately; no pcm_valid after release until a fresh sync is found.
- Acquisition: send random bits, then 0x9B, then payload 0x12,0x34,0x56,0x78 at 1 bit per cycle -> locked rises 1 cycle after the sync LSB; four pcm_valid pulses carrying those values with slot_idx 0..3, each 1 cycle after the slot's 8th bit.
- Sparse strobes: same frame with bit_valid every 5 cycles, plus a random gap of 1..7 cycles -> identical pcmlog/slot_idx sequence; pcmlog holds between pulses.
- Flywheel: locked, then frames 2 and 3 carry sync 0x9A -> lock kept and payload still delivered; frame 4 with a correct sync clears the miss counter; a subsequent single bad sync does not drop lock.
- Loss of lock: 3 consecutive bad sync words -> sync_loss pulse and locked=0 on the 3rd bad sync's LSB+1 cycle; no further pcm_valid until a fresh 0x9B is received.
- False-sync overlap: stream ...1001 1011 (0x9B) whose leading bits overlap a partial 0x9B candidate -> acquisition aligns on the exact bit position; first payload byte is correct.

Source files
------------

// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM deframing path.
package pcm_pkg;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    SYNC_CHECK
  } pcm_state_t;

  localparam int PCM_LOG_W = 8;
  localparam int PCM_LIN_W = 13;

  localparam logic [PCM_LOG_W-1:0] DEF_SYNC_WORD = 8'h9B;

endpackage

// File: rtl/pcm_bit_shifter.sv
// Serial-in/parallel-out byte window with a bit counter that flags each completed byte.
module pcm_bit_shifter
  import pcm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 hold_cnt,
  output logic [PCM_LOG_W-1:0] nxt,
  output logic                 byte_done
);

  // Only the seven most recent bits need storing; the incoming bit completes the byte window.
  logic [PCM_LOG_W-2:0] hist;
  logic [2:0]           cnt;

  assign nxt       = {hist, bit_in};
  assign byte_done = bit_valid && (cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      cnt  <= '0;
    end else if (bit_valid) begin
      hist <= nxt[PCM_LOG_W-2:0];
      cnt  <= hold_cnt ? 3'd0 : cnt + 3'd1;
    end
  end

endmodule

// File: rtl/pcm_deframer.sv
// Frame-sync hunter and payload slicer between the FSK bit recovery and the PCM expander.
module pcm_deframer
  import pcm_pkg::*;
#(
  parameter logic [PCM_LOG_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
  parameter int                   N_SLOTS    = 4,
  parameter int                   MISS_LIMIT = 3,
  localparam int                  SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [PCM_LOG_W-1:0] pcmlog,
  output logic                 pcm_valid,
  output logic [SLOT_W-1:0]    slot_idx,
  output logic                 locked,
  output logic                 sync_loss
);

  pcm_state_t           state;
  logic [SLOT_W-1:0]    slot_cnt;
  logic [3:0]           miss;
  logic [PCM_LOG_W-1:0] nxt;
  logic                 byte_done;

  // Bit counter is pinned at zero while hunting so the first payload bit after sync is bit 0.
  pcm_bit_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .hold_cnt  (state == HUNT),
    .nxt       (nxt),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot_cnt  <= '0;
      miss      <= '0;
      pcmlog    <= '0;
      pcm_valid <= 1'b0;
      slot_idx  <= '0;
      locked    <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      sync_loss <= 1'b0;
      if (bit_valid) begin
        case (state)
          HUNT: begin
            // Sliding search on every bit, so overlapping candidates are caught.
            if (nxt == SYNC_WORD) begin
              state    <= PAYLOAD;
              slot_cnt <= '0;
              miss     <= '0;
              locked   <= 1'b1;
            end
          end
          PAYLOAD: begin
            if (byte_done) begin
              pcmlog    <= nxt;
              slot_idx  <= slot_cnt;
              pcm_valid <= 1'b1;
              if (slot_cnt == SLOT_W'(N_SLOTS - 1)) begin
                slot_cnt <= '0;
                state    <= SYNC_CHECK;
              end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
              end
            end
          end
          SYNC_CHECK: begin
            if (byte_done) begin
              if (nxt == SYNC_WORD) begin
                miss  <= '0;
                state <= PAYLOAD;
              end else if (int'(miss) + 1 < MISS_LIMIT) begin
                // Flywheel: ride through an isolated bad sync word.
                miss  <= miss + 4'd1;
                state <= PAYLOAD;
              end else begin
                miss      <= '0;
                state     <= HUNT;
                locked    <= 1'b0;
                sync_loss <= 1'b1;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcm_deframer.sv
// Randomized bench for pcm_deframer with a frame-position reference model.
module tb_pcm_deframer;

  localparam int          N_SLOTS    = 4;
  localparam int          MISS_LIMIT = 3;
  localparam logic [7:0]  SYNC       = 8'h9B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] pcmlog;
  logic       pcm_valid;
  logic [1:0] slot_idx;
  logic       locked;
  logic       sync_loss;

  int vectors = 0;
  int errors  = 0;

  // Reference model: byte window, lock flag, bit position within the locked frame.
  logic [7:0] m_win;
  bit         m_lock;
  int         m_pos;
  int         m_miss;
  logic [7:0] m_pcm;
  logic [1:0] m_slot;
  bit         e_valid;
  bit         e_loss;
  int         loss_seen;
  logic [9:0] obs[$];

  pcm_deframer #(.SYNC_WORD(SYNC), .N_SLOTS(N_SLOTS), .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .pcmlog    (pcmlog),
    .pcm_valid (pcm_valid),
    .slot_idx  (slot_idx),
    .locked    (locked),
    .sync_loss (sync_loss)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_win  = 8'h00;
    m_lock = 1'b0;
    m_pos  = 0;
    m_miss = 0;
    m_pcm  = 8'h00;
    m_slot = 2'd0;
  endfunction

  // A locked frame is N_SLOTS payload bytes followed by one sync byte, counted in bits.
  function automatic void model_bit(input bit b);
    e_valid = 1'b0;
    e_loss  = 1'b0;
    m_win   = {m_win[6:0], b};
    if (!m_lock) begin
      if (m_win == SYNC) begin
        m_lock = 1'b1;
        m_pos  = 0;
        m_miss = 0;
      end
    end else begin
      m_pos++;
      if (m_pos % 8 == 0) begin
        if (m_pos / 8 <= N_SLOTS) begin
          e_valid = 1'b1;
          m_pcm   = m_win;
          m_slot  = 2'(m_pos / 8 - 1);
        end else begin
          m_pos = 0;
          if (m_win == SYNC) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == MISS_LIMIT) begin
              m_lock = 1'b0;
              m_miss = 0;
              e_loss = 1'b1;
            end
          end
        end
      end
    end
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    obs.delete();
    loss_seen = 0;
  endtask

  // Drives one strobed bit followed by idle cycles, checking every cycle against the model.
  task automatic send_bit(input bit b, input int gap);
    bit_in = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_in = $urandom_range(0, 1);
    model_bit(b);
    vectors++;
    if (pcm_valid !== e_valid || locked !== m_lock || sync_loss !== e_loss ||
        pcmlog !== m_pcm || (e_valid && slot_idx !== m_slot)) begin
      errors++;
      $display("FAIL strobe: got valid=%0b pcm=%h slot=%0d lock=%0b loss=%0b, want valid=%0b pcm=%h slot=%0d lock=%0b loss=%0b",
               pcm_valid, pcmlog, slot_idx, locked, sync_loss, e_valid, m_pcm, m_slot, m_lock, e_loss);
    end
    if (pcm_valid === 1'b1) obs.push_back({slot_idx, pcmlog});
    if (sync_loss === 1'b1) loss_seen++;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      vectors++;
      if (pcm_valid !== 1'b0 || sync_loss !== 1'b0 || pcmlog !== m_pcm || locked !== m_lock) begin
        errors++;
        $display("FAIL idle: got valid=%0b loss=%0b pcm=%h lock=%0b, want 0 0 %h %0b",
                 pcm_valid, sync_loss, pcmlog, locked, m_pcm, m_lock);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int glo, input int ghi);
    logic [7:0] t;
    t = v;
    for (int i = 7; i >= 0; i--) send_bit(t[i], $urandom_range(glo, ghi));
  endtask

  task automatic send_frame(input logic [7:0] s, input int glo, input int ghi);
    send_byte(s, glo, ghi);
    for (int k = 0; k < N_SLOTS; k++) send_byte(8'($urandom), glo, ghi);
  endtask

  // Random prefix that cannot form the sync word before the real one completes.
  task automatic send_clean_prefix(input int glo, input int ghi);
    logic [23:0] v;
    bit          bad;
    do begin
      v = {8'h00, 8'($urandom), SYNC};
      bad = 1'b0;
      for (int i = 15; i >= 1; i--) if (v[i+7 -: 8] == SYNC) bad = 1'b1;
    end while (bad);
    send_byte(v[15:8], glo, ghi);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    #2;
    vectors++;
    if (pcmlog !== 8'h00 || pcm_valid !== 1'b0 || slot_idx !== 2'd0 || locked !== 1'b0 || sync_loss !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got pcm=%h v=%0b slot=%0d lock=%0b loss=%0b, want all 0",
               pcmlog, pcm_valid, slot_idx, locked, sync_loss);
    end
    apply_reset();
    send_byte(SYNC, 0, 0);
    send_byte(8'hA5, 0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    // Assert reset mid-cycle while a strobe is pending.
    bit_in = 1'b1;
    bit_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (pcmlog !== 8'h00 || pcm_valid !== 1'b0 || slot_idx !== 2'd0 || locked !== 1'b0 || sync_loss !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got pcm=%h v=%0b slot=%0d lock=%0b loss=%0b, want all 0",
               pcmlog, pcm_valid, slot_idx, locked, sync_loss);
    end
    apply_reset();
    for (int k = 0; k < 5; k++) send_byte(8'h00, 0, 1);
    vectors++;
    if (obs.size() != 0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d pulses lock=%0b, want 0 pulses lock=0", obs.size(), locked);
    end
  endtask

  task automatic test_acquire(input int glo, input int ghi, input string tag);
    logic [7:0] pay[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    apply_reset();
    send_clean_prefix(glo, ghi);
    send_byte(SYNC, glo, ghi);
    vectors++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL %s_lock: got locked=%0b, want 1", tag, locked);
    end
    for (int k = 0; k < 4; k++) send_byte(pay[k], glo, ghi);
    vectors++;
    if (obs.size() != 4) begin
      errors++;
      $display("FAIL %s_count: got %0d pulses, want 4", tag, obs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== {2'(k), pay[k]}) begin
          errors++;
          $display("FAIL %s_slot%0d: got slot=%0d pcm=%h, want slot=%0d pcm=%h",
                   tag, k, obs[k][9:8], obs[k][7:0], k, pay[k]);
        end
      end
    end
  endtask

  task automatic test_flywheel();
    apply_reset();
    send_clean_prefix(0, 0);
    send_frame(SYNC, 0, 2);
    send_frame(8'h9A, 0, 2);
    send_frame(8'h9A, 0, 2);
    send_frame(SYNC, 0, 2);
    send_frame(8'h1B, 0, 2);
    send_byte(SYNC, 0, 2);
    vectors++;
    if (locked !== 1'b1 || loss_seen != 0 || obs.size() != 5 * N_SLOTS) begin
      errors++;
      $display("FAIL flywheel: got lock=%0b losses=%0d pulses=%0d, want 1 0 %0d",
               locked, loss_seen, obs.size(), 5 * N_SLOTS);
    end
  endtask

  task automatic test_loss();
    apply_reset();
    send_clean_prefix(0, 0);
    send_frame(SYNC, 0, 1);
    send_frame(8'h00, 0, 1);
    send_frame(8'hFF, 0, 1);
    send_byte(8'h9A, 0, 1);
    vectors++;
    if (locked !== 1'b0 || loss_seen != 1) begin
      errors++;
      $display("FAIL loss: got lock=%0b losses=%0d, want 0 1", locked, loss_seen);
    end
    obs.delete();
    for (int k = 0; k < 6; k++) send_byte(8'h00, 0, 1);
    vectors++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL loss_quiet: got %0d pulses, want 0", obs.size());
    end
    send_frame(SYNC, 0, 1);
    send_byte(SYNC, 0, 1);
    vectors++;
    if (locked !== 1'b1 || obs.size() != N_SLOTS) begin
      errors++;
      $display("FAIL loss_relock: got lock=%0b pulses=%0d, want 1 %0d", locked, obs.size(), N_SLOTS);
    end
  endtask

  task automatic test_overlap();
    logic [11:0] pre = 12'b1001_1001_1011;
    logic [7:0]  p0;
    apply_reset();
    for (int i = 11; i >= 0; i--) begin
      send_bit(pre[i], 0);
      vectors++;
      if (locked !== (i == 0)) begin
        errors++;
        $display("FAIL overlap_bit%0d: got locked=%0b, want %0b", i, locked, i == 0);
      end
    end
    p0 = 8'($urandom);
    send_byte(p0, 0, 0);
    vectors++;
    if (obs.size() != 1 || obs[0] !== {2'd0, p0}) begin
      errors++;
      $display("FAIL overlap_first: got %0d pulses first=%h, want 1 pulse %h",
               obs.size(), (obs.size() > 0) ? obs[0] : 10'h0, p0);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 0, 0);
      else send_frame(($urandom_range(0, 2) == 0) ? 8'($urandom) : SYNC, 0, $urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_acquire(0, 0, "acq");
    test_acquire(4, 10, "sparse");
    test_flywheel();
    test_loss();
    test_overlap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
